// File: rtl/shift_register_demultiplexer.sv
// Four-channel serial-to-parallel demultiplexer: each accepted bit shifts MSB-first
// into the channel chosen by {sel0, sel1}; a full word is published on outk with a done pulse.
module shift_register_demultiplexer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel0,
    input  logic             sel1,
    input  logic             in,
    input  logic             in_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             done0,
    output logic             done1,
    output logic             done2,
    output logic             done3,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]            chan_sel;
    logic [3:0][WIDTH-1:0] word_bus;
    logic [3:0]            done_bus;
    logic [3:0]            active;

    assign chan_sel = {sel0, sel1};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            logic [WIDTH-1:0] sr_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic [WIDTH-1:0] word_reg;
            logic             done_reg;
            logic             accept;
            logic             last_bit;
            logic [WIDTH-1:0] shifted;

            // clear wins over a simultaneous valid bit, so it never reaches the shifter
            assign accept   = in_valid && !clear && (chan_sel == 2'(gi));
            assign last_bit = (cnt_reg == LAST);
            assign shifted  = {sr_reg[WIDTH-2:0], in};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr_reg   <= '0;
                    cnt_reg  <= '0;
                    word_reg <= '0;
                    done_reg <= 1'b0;
                end else begin
                    done_reg <= accept && last_bit;
                    if (clear) begin
                        sr_reg  <= '0;
                        cnt_reg <= '0;
                    end else if (accept) begin
                        if (last_bit) begin
                            word_reg <= shifted;
                            sr_reg   <= '0;
                            cnt_reg  <= '0;
                        end else begin
                            sr_reg  <= shifted;
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
            end

            assign word_bus[gi] = word_reg;
            assign done_bus[gi] = done_reg;
            assign active[gi]   = (cnt_reg != '0);
        end
    endgenerate

    assign out0  = word_bus[0];
    assign out1  = word_bus[1];
    assign out2  = word_bus[2];
    assign out3  = word_bus[3];
    assign done0 = done_bus[0];
    assign done1 = done_bus[1];
    assign done2 = done_bus[2];
    assign done3 = done_bus[3];
    assign busy  = |active;

endmodule

// File: tb/tb_shift_register_demultiplexer.sv
// Randomised and directed checks of the four-channel demultiplexer against a
// word-level model that tracks each channel as an integer value and bit count.
module tb_shift_register_demultiplexer;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sel0 = 1'b0, sel1 = 1'b0, in = 1'b0, in_valid = 1'b0, clear = 1'b0;
    logic [W-1:0] out0, out1, out2, out3;
    logic         done0, done1, done2, done3, busy;

    int checks = 0;
    int errors = 0;

    int unsigned  m_part [4];
    int unsigned  m_cnt  [4];
    int unsigned  m_out  [4];
    int unsigned  m_done [4];

    shift_register_demultiplexer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .sel0(sel0), .sel1(sel1), .in(in),
        .in_valid(in_valid), .clear(clear),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .done0(done0), .done1(done1), .done2(done2), .done3(done3), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_busy();
        int b = 0;
        for (int k = 0; k < 4; k++) if (m_cnt[k] != 0) b = 1;
        return b;
    endfunction

    // Model: each channel accumulates value = value*2 + bit until W bits are collected.
    initial begin
        for (int k = 0; k < 4; k++) begin
            m_part[k] = 0; m_cnt[k] = 0; m_out[k] = 0; m_done[k] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < 4; k++) begin
                    m_part[k] = 0; m_cnt[k] = 0; m_out[k] = 0; m_done[k] = 0;
                end
            end else begin
                for (int k = 0; k < 4; k++) m_done[k] = 0;
                if (clear) begin
                    for (int k = 0; k < 4; k++) begin
                        m_part[k] = 0; m_cnt[k] = 0;
                    end
                end else if (in_valid) begin
                    int k;
                    k = 2 * int'(sel0) + int'(sel1);
                    m_part[k] = m_part[k] * 2 + int'(in);
                    m_cnt[k]++;
                    if (m_cnt[k] == W) begin
                        m_out[k]  = m_part[k];
                        m_done[k] = 1;
                        m_part[k] = 0;
                        m_cnt[k]  = 0;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            chk("out0", int'(out0), int'(m_out[0]));
            chk("out1", int'(out1), int'(m_out[1]));
            chk("out2", int'(out2), int'(m_out[2]));
            chk("out3", int'(out3), int'(m_out[3]));
            chk("done0", int'(done0), int'(m_done[0]));
            chk("done1", int'(done1), int'(m_done[1]));
            chk("done2", int'(done2), int'(m_done[2]));
            chk("done3", int'(done3), int'(m_done[3]));
            chk("busy", int'(busy), m_busy());
        end
    end

    task automatic send(input int k, input logic b);
        sel0 = k[1]; sel1 = k[0]; in = b; in_valid = 1'b1; clear = 1'b0;
        @(posedge clk); #1;
        $display("tx ch%0d bit=%0b out=%h/%h/%h/%h done=%b%b%b%b busy=%b",
                 k, b, out0, out1, out2, out3, done0, done1, done2, done3, busy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0; clear = 1'b0;
            sel0 = i[0]; sel1 = i[1]; in = ~i[0];
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0; #1;
        $display("tx async reset");
        chk("rst_out0", int'(out0), 0);
        chk("rst_out3", int'(out3), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done3", int'(done3), 0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2;
        chk("reset_out0", int'(out0), 0);
        chk("reset_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // single word on ch0
        send(0, 1); chk("b1_busy", int'(busy), 1); chk("b1_done0", int'(done0), 0);
        send(0, 0); chk("b2_busy", int'(busy), 1);
        send(0, 1); chk("b3_busy", int'(busy), 1); chk("b3_done0", int'(done0), 0);
        send(0, 1);
        chk("w_out0", int'(out0), 'b1011); chk("w_done0", int'(done0), 1);
        chk("w_busy", int'(busy), 0); chk("w_out1", int'(out1), 0);
        idle(1);
        chk("w_done0_clr", int'(done0), 0);

        // interleaved channels
        send(2, 1); send(2, 1);
        send(3, 0); send(3, 1); send(3, 0); send(3, 1);
        chk("il_out3", int'(out3), 'b0101); chk("il_done3", int'(done3), 1);
        chk("il_out2_pending", int'(out2), 0);
        send(2, 0); chk("il_done3_off", int'(done3), 0);
        send(2, 0);
        chk("il_out2", int'(out2), 'b1100); chk("il_done2", int'(done2), 1);

        // back-to-back words on ch1
        send(1, 1); send(1, 0); send(1, 0); send(1, 1);
        chk("bb_out1a", int'(out1), 'b1001); chk("bb_done1a", int'(done1), 1);
        send(1, 0); chk("bb_done1_gap", int'(done1), 0);
        send(1, 1); send(1, 1); send(1, 0);
        chk("bb_out1b", int'(out1), 'b0110); chk("bb_done1b", int'(done1), 1);

        // clear beats a completing bit
        send(0, 1); send(0, 1); send(0, 1);
        sel0 = 0; sel1 = 0; in = 1; in_valid = 1; clear = 1;
        @(posedge clk); #1; clear = 0; in_valid = 0;
        chk("clr_done0", int'(done0), 0); chk("clr_out0", int'(out0), 'b1011);
        chk("clr_busy", int'(busy), 0);
        send(0, 0); send(0, 0); send(0, 1); send(0, 0);
        chk("clr_out0_new", int'(out0), 'b0010);

        // reset mid-word
        send(3, 1); send(3, 0);
        pulse_reset();
        send(3, 0); send(3, 1); send(3, 1); send(3, 1);
        chk("rst_out3_new", int'(out3), 'b0111); chk("rst_done3_new", int'(done3), 1);

        // idle with toggling inputs
        send(1, 1); send(1, 1);
        idle(10);
        chk("idle_busy", int'(busy), 1); chk("idle_out3", int'(out3), 'b0111);
        chk("idle_out1", int'(out1), 0);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            sel0 = 1'($urandom); sel1 = 1'($urandom); in = 1'($urandom);
            in_valid = (r < 75);
            clear = (r >= 97);
            @(posedge clk); #1;
            if ($urandom_range(0, 299) == 0) pulse_reset();
        end
        in_valid = 0; clear = 0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
